// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order requests with a bounded number in flight, a DEPTH-entry
// response queue toward Decode, and redirect flush. Define FETCH_BYPASS_EN for same-cycle response bypass.
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       Reset,
  output logic                       IReq,
  output logic [31:0]                IAddr,
  input  logic                       IRvalid,
  input  logic [31:0]                IRdata,
  output logic                       InstrValid,
  output logic [31:0]                Instr,
  output logic [31:0]                InstrPC,
  input  logic                       InstrReady,
  input  logic                       Redirect,
  input  logic [31:0]                RedirectPC,
  output logic [$clog2(DEPTH+1)-1:0] Level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic [31:0]   occupancy;
  logic [31:0]   redirect_pc;
  logic          issue;
  logic          resp_ok;
  logic          resp_live;
  logic          q_valid;
  logic          bypass;
  logic          pop;
  logic          q_pop;
  logic          push;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
    occupancy   = 32'(count) + 32'(outstanding);
    redirect_pc = RedirectPC & 32'hFFFF_FFFC;
    // Queue slots are reserved for every request in flight, so a response always has room.
    issue       = Reset && !Redirect && (outstanding < OW'(MAX_OUTSTANDING)) && (occupancy < 32'(DEPTH));
    resp_ok     = IRvalid && (outstanding != '0);
    resp_live   = resp_ok && (drop == '0) && !Redirect;
    q_valid     = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypass      = !q_valid && resp_live;
`else
    bypass      = 1'b0;
`endif
    InstrValid  = q_valid || bypass;
    Instr       = '0;
    InstrPC     = '0;
    if (q_valid) begin
      Instr   = q_data[rd_ptr];
      InstrPC = q_pc[rd_ptr];
    end else if (bypass) begin
      Instr   = IRdata;
      InstrPC = resp_pc;
    end
    pop   = InstrValid && InstrReady && !Redirect;
    q_pop = q_valid && pop;
    push  = resp_live && !(bypass && InstrReady);
  end

  assign IReq  = issue;
  assign IAddr = fetch_pc;
  assign Level = count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (Redirect) begin
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      // Stale requests are already part of outstanding, so everything still in flight gets dropped.
      outstanding <= outstanding - OW'(resp_ok);
      drop        <= outstanding - OW'(resp_ok);
    end else begin
      if (issue)     fetch_pc <= fetch_pc + 32'd4;
      if (resp_live) resp_pc  <= resp_pc + 32'd4;
      outstanding <= outstanding + OW'(issue) - OW'(resp_ok);
      if (resp_ok && (drop != '0)) drop <= drop - OW'(1);
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (q_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(q_pop);
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_data[wr_ptr] <= IRdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule
